// File: rtl/redundant_normalize.sv
// Serial carry-propagation normaliser for redundant-form modular sums.
// One limb per cycle; a trial subtraction of MODULUS runs alongside and picks the canonical result.
module redundant_normalize #(
   parameter int NUM_ELEMENTS = 17,
   parameter int BIT_LEN      = 17,
   parameter int WORD_LEN     = 16,
   parameter logic [(NUM_ELEMENTS-1)*WORD_LEN-1:0] MODULUS = (256'd1 << 255) - 256'd19
) (
   input  logic                                         clk,
   input  logic                                         rst_n,
   input  logic                                         in_valid,
   output logic                                         in_ready,
   input  logic [NUM_ELEMENTS-1:0][BIT_LEN-1:0]         SUM,
   output logic                                         out_valid,
   input  logic                                         out_ready,
   output logic [NUM_ELEMENTS-2:0][WORD_LEN-1:0]        RESULT,
   output logic                                         out_err
);

   localparam int IDX_W   = $clog2(NUM_ELEMENTS);
   localparam int CARRY_W = BIT_LEN + 1 - WORD_LEN;
   localparam int MOD_W   = (NUM_ELEMENTS-1)*WORD_LEN;
   localparam logic [MOD_W+WORD_LEN-1:0] MOD_EXT = {{WORD_LEN{1'b0}}, MODULUS};
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEMENTS-1);

   typedef enum logic [1:0] {IDLE, PROC, DONE} state_t;

   state_t                      state_reg, state_next;
   logic [BIT_LEN-1:0]          limb_reg [NUM_ELEMENTS];
   logic [IDX_W-1:0]            idx_reg;
   logic [CARRY_W-1:0]          carry_reg;
   logic                        borrow_reg;
   logic [WORD_LEN-1:0]         w_reg [NUM_ELEMENTS-1];
   logic [WORD_LEN-1:0]         d_reg [NUM_ELEMENTS-1];
   logic [NUM_ELEMENTS-2:0][WORD_LEN-1:0] result_reg;
   logic                        err_reg;

   logic [WORD_LEN-1:0]         mod_words [NUM_ELEMENTS];
   logic [NUM_ELEMENTS-2:0][WORD_LEN-1:0] res_sel;
   logic [BIT_LEN:0]            acc;
   logic [WORD_LEN:0]           diff;
   logic [WORD_LEN-1:0]         w_cur, d_cur;
   logic [CARRY_W-1:0]          carry_cur;
   logic                        borrow_cur;
   logic                        sel_d;
   logic                        err_cur;
   logic                        accept;
   logic                        last;

   // The extra zero word makes the top limb subtract nothing.
   generate
      for (genvar gi = 0; gi < NUM_ELEMENTS; gi++) begin : g_mod
         assign mod_words[gi] = MOD_EXT[gi*WORD_LEN +: WORD_LEN];
      end
   endgenerate

   always_comb begin
      acc        = {1'b0, limb_reg[idx_reg]} + {{(BIT_LEN+1-CARRY_W){1'b0}}, carry_reg};
      w_cur      = acc[WORD_LEN-1:0];
      carry_cur  = acc[BIT_LEN:WORD_LEN];
      diff       = {1'b0, w_cur} - {1'b0, mod_words[idx_reg]} - {{WORD_LEN{1'b0}}, borrow_reg};
      d_cur      = diff[WORD_LEN-1:0];
      borrow_cur = diff[WORD_LEN];
      sel_d      = ~borrow_cur;
      err_cur    = ((sel_d ? d_cur : w_cur) != '0) || (carry_cur != '0);
   end

   generate
      for (genvar gi = 0; gi < NUM_ELEMENTS-1; gi++) begin : g_sel
         assign res_sel[gi] = sel_d ? d_reg[gi] : w_reg[gi];
      end
   endgenerate

   assign accept = (state_reg == IDLE) && in_valid;
   assign last   = (idx_reg == LAST_IDX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (in_valid)  state_next = PROC;
         PROC:    if (last)      state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_reg == IDLE);
      out_valid = (state_reg == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_ELEMENTS; i++) limb_reg[i] <= '0;
         for (int i = 0; i < NUM_ELEMENTS-1; i++) begin
            w_reg[i] <= '0;
            d_reg[i] <= '0;
         end
         idx_reg    <= '0;
         carry_reg  <= '0;
         borrow_reg <= 1'b0;
         result_reg <= '0;
         err_reg    <= 1'b0;
      end else if (accept) begin
         for (int i = 0; i < NUM_ELEMENTS; i++) limb_reg[i] <= SUM[i];
         idx_reg    <= '0;
         carry_reg  <= '0;
         borrow_reg <= 1'b0;
      end else if (state_reg == PROC) begin
         carry_reg  <= carry_cur;
         borrow_reg <= borrow_cur;
         for (int i = 0; i < NUM_ELEMENTS-1; i++) begin
            if (idx_reg == IDX_W'(i)) begin
               w_reg[i] <= w_cur;
               d_reg[i] <= d_cur;
            end
         end
         if (last) begin
            // Top word and final carry only feed the range check.
            result_reg <= res_sel;
            err_reg    <= err_cur;
         end else begin
            idx_reg <= idx_reg + 1'b1;
         end
      end
   end

   assign RESULT  = result_reg;
   assign out_err = err_reg;

endmodule

// File: tb/tb_redundant_normalize.sv
// Directed bench for redundant_normalize: expectations are queued at issue and checked by a monitor.
module tb_redundant_normalize;

   localparam int NE = 17;
   localparam int BL = 17;
   localparam int WL = 16;

   typedef logic [NE-1:0][BL-1:0] sum_t;
   typedef struct {
      logic [255:0] res;
      logic         err;
      logic         chk_res;
   } exp_t;

   logic                       clk = 1'b0;
   logic                       rst_n;
   logic                       in_valid;
   logic                       in_ready;
   sum_t                       sum;
   logic                       out_valid;
   logic                       out_ready;
   logic [NE-2:0][WL-1:0]      result;
   logic                       out_err;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   redundant_normalize dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .SUM(sum), .out_valid(out_valid), .out_ready(out_ready),
      .RESULT(result), .out_err(out_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   // Monitor: one pop per completed output transfer.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_output: got RESULT %h with empty queue", result);
         end else begin
            exp_t e;
            e = q.pop_front();
            if (e.chk_res) chk("mon_result", result, e.res);
            chk("mon_err", {255'd0, out_err}, {255'd0, e.err});
         end
      end
   end

   function automatic sum_t mk_mod(input logic [BL-1:0] low);
      sum_t s;
      s = '0;
      s[0] = low;
      for (int i = 1; i < 15; i++) s[i] = 17'h0FFFF;
      s[15] = 17'h07FFF;
      return s;
   endfunction

   task automatic push(input logic [255:0] res, input logic err, input logic chk_res);
      exp_t e;
      e.res = res;
      e.err = err;
      e.chk_res = chk_res;
      q.push_back(e);
   endtask

   task automatic send(input sum_t s);
      int guard;
      guard = 0;
      sum = s;
      in_valid = 1'b1;
      while (!in_ready && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      if (guard >= 50) begin
         n_cmp++;
         n_bad++;
         $display("FAIL send_timeout: in_ready got 0 expected 1");
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      while (!out_valid && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
      end
   endtask

   task automatic run(input string name, input sum_t s, input logic [255:0] res,
                      input logic err, input logic chk_res);
      int c;
      push(res, err, chk_res);
      send(s);
      wait_done(c);
      chk({name, "_latency"}, 256'(c), 256'd17);
      @(posedge clk); #1;
      chk({name, "_valid_drop"}, {255'd0, out_valid}, 256'd0);
      chk({name, "_ready_back"}, {255'd0, in_ready}, 256'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      sum_t zero_s, t2_s, t6a_s, t6b_s, tmp_s;
      int   c;
      zero_s = '0;
      t2_s = '0;   t2_s[0]  = 17'h1FFFF;
      t6a_s = '0;  t6a_s[16] = 17'h00002;
      t6b_s = '0;  t6b_s[15] = 17'h0FFFF;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; sum = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", {255'd0, in_ready}, 256'd1);
      chk("rst_out_valid", {255'd0, out_valid}, 256'd0);
      chk("rst_result", result, 256'd0);
      chk("rst_err", {255'd0, out_err}, 256'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run("zero", zero_s, 256'd0, 1'b0, 1'b1);
      run("carry", t2_s, 256'h1_FFFF, 1'b0, 1'b1);
      run("mod_exact", mk_mod(17'h0FFED), 256'd0, 1'b0, 1'b1);
      run("mod_plus5", mk_mod(17'h0FFF2), 256'd5, 1'b0, 1'b1);

      // Backpressure with in_valid held and SUM changing.
      out_ready = 1'b0;
      push(256'd5, 1'b0, 1'b1);
      send(mk_mod(17'h0FFF2));
      wait_done(c);
      chk("bp_latency", 256'(c), 256'd17);
      for (int i = 0; i < 10; i++) begin
         tmp_s = '0;
         tmp_s[i] = 17'(i + 3);
         sum = tmp_s;
         in_valid = 1'b1;
         @(posedge clk); #1;
         chk("bp_valid_hold", {255'd0, out_valid}, 256'd1);
         chk("bp_ready_low", {255'd0, in_ready}, 256'd0);
         chk("bp_result_hold", result, 256'd5);
         chk("bp_err_hold", {255'd0, out_err}, 256'd0);
      end
      sum = t2_s;
      push(256'h1_FFFF, 1'b0, 1'b1);
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_release_valid", {255'd0, out_valid}, 256'd0);
      chk("bp_release_ready", {255'd0, in_ready}, 256'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp_next_accepted", {255'd0, in_ready}, 256'd0);
      wait_done(c);
      chk("bp_next_latency", 256'(c), 256'd17);
      @(posedge clk); #1;

      // Reset in the middle of PROC discards the operation.
      send(t6b_s);
      repeat (8) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", {255'd0, out_valid}, 256'd0);
      chk("midrst_ready", {255'd0, in_ready}, 256'd1);
      chk("midrst_result", result, 256'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      run("after_rst", t2_s, 256'h1_FFFF, 1'b0, 1'b1);

      run("overflow", t6a_s, 256'd0, 1'b1, 1'b0);
      run("top_word", t6b_s, {16'h7FFF, 224'd0, 16'h0013}, 1'b0, 1'b1);

      repeat (3) @(posedge clk);
      #1;
      chk("queue_drained", 256'(q.size()), 256'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
